// File: rtl/usr_pkg.sv
// ----------------------------------------------------------------------------
// usr_pkg
// Shared definitions for the universal shift register with burst engine:
//   - 3-bit mode encodings MODE_HOLD..MODE_RSVD
//   - FSM state type (ST_IDLE, ST_RUN)
//   - is_shift_mode(): true for modes a burst is allowed to repeat
// ----------------------------------------------------------------------------
package usr_pkg;

    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_SHL  = 3'd1;
    localparam logic [2:0] MODE_SHR  = 3'd2;
    localparam logic [2:0] MODE_LOAD = 3'd3;
    localparam logic [2:0] MODE_ROL  = 3'd4;
    localparam logic [2:0] MODE_ROR  = 3'd5;
    localparam logic [2:0] MODE_ASR  = 3'd6;
    localparam logic [2:0] MODE_RSVD = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Hold, load and the reserved code make no sense repeated N times, so a
    // burst request carrying them degrades to an ordinary single step.
    function automatic logic is_shift_mode(input logic [2:0] mode);
        return (mode == MODE_SHL) || (mode == MODE_SHR) || (mode == MODE_ROL) ||
               (mode == MODE_ROR) || (mode == MODE_ASR);
    endfunction

endpackage

// File: rtl/usr_burst_if.sv
// ----------------------------------------------------------------------------
// usr_burst_if
// Control/data bundle of usr_burst.
//   master (requester): drives en, select, lin, rin, par_in, start, count;
//                       observes q, sout_l, sout_r, busy, done.
//   slave  (usr_burst): the reverse directions.
// ----------------------------------------------------------------------------
interface usr_burst_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             en;
    logic [2:0]       select;
    logic             lin;
    logic             rin;
    logic [WIDTH-1:0] par_in;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] q;
    logic             sout_l;
    logic             sout_r;
    logic             busy;
    logic             done;

    modport master (
        output en, select, lin, rin, par_in, start, count,
        input  q, sout_l, sout_r, busy, done
    );

    modport slave (
        input  en, select, lin, rin, par_in, start, count,
        output q, sout_l, sout_r, busy, done
    );
endinterface

// File: rtl/usr_step.sv
// ----------------------------------------------------------------------------
// usr_step
// Purely combinational next-value function of the shift register.
//   q      : current register contents
//   mode   : operation code (usr_pkg MODE_*)
//   lin    : serial bit entering the MSB on shr
//   rin    : serial bit entering the LSB on shl
//   par_in : parallel load data
//   nxt    : value the register takes if this step is applied
// ----------------------------------------------------------------------------
module usr_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic             lin,
    input  logic             rin,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] nxt
);

    always_comb begin
        nxt = q;
        case (mode)
            MODE_SHL:  nxt = {q[WIDTH-2:0], rin};
            MODE_SHR:  nxt = {lin, q[WIDTH-1:1]};
            MODE_LOAD: nxt = par_in;
            MODE_ROL:  nxt = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR:  nxt = {q[0], q[WIDTH-1:1]};
            MODE_ASR:  nxt = {q[WIDTH-1], q[WIDTH-1:1]};
            default:   nxt = q;
        endcase
    end

endmodule

// File: rtl/usr_burst.sv
// ----------------------------------------------------------------------------
// usr_burst
// Parametrised universal shift register with a burst engine that repeats a
// shift mode `count` times from a single start request.
//   clk : rising-edge clock
//   clr : asynchronous active-low reset (abandons any burst, no done pulse)
//   bus : usr_burst_if.slave
//         en/select/lin/rin/par_in  single-step controls (acted on when idle)
//         start/count               burst request, sampled when idle
//         q                         register contents (registered)
//         sout_l/sout_r             q MSB / LSB (combinational from q)
//         busy                      burst in progress (registered)
//         done                      one-cycle pulse at burst end (registered)
// ----------------------------------------------------------------------------
module usr_burst
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic        clk,
    input  logic        clr,
    usr_burst_if.slave  bus
);

    state_e           state_q;
    logic [2:0]       mode_q;
    logic [CNT_W-1:0] rem_q;
    logic [WIDTH-1:0] q_q;
    logic             busy_q;
    logic             done_q;

    logic [2:0]       step_mode;
    logic [WIDTH-1:0] q_d;

    // While running, the latched mode drives the step; the live select is
    // ignored so upstream may change it freely during a burst.
    assign step_mode = (state_q == ST_RUN) ? mode_q : bus.select;

    usr_step #(.WIDTH(WIDTH)) u_step (
        .q      (q_q),
        .mode   (step_mode),
        .lin    (bus.lin),
        .rin    (bus.rin),
        .par_in (bus.par_in),
        .nxt    (q_d)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_HOLD;
            rem_q   <= '0;
            q_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start && is_shift_mode(bus.select)) begin
                        // Capture edge: q is left untouched, shifting starts
                        // on the following edge.
                        if (bus.count != '0) begin
                            mode_q  <= bus.select;
                            rem_q   <= bus.count;
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end else if (bus.en) begin
                        q_q <= q_d;
                    end
                end
                ST_RUN: begin
                    q_q   <= q_d;
                    rem_q <= rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.q      = q_q;
    assign bus.sout_l = q_q[WIDTH-1];
    assign bus.sout_r = q_q[0];
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_usr_burst.sv
// ----------------------------------------------------------------------------
// tb_usr_burst
// Directed and randomized stimulus for usr_burst (WIDTH=8) checked against a
// behavioural model that computes shifts with plain integer arithmetic and
// tracks a burst as "shifts still owed".
// ----------------------------------------------------------------------------
module tb_usr_burst;

    localparam int W  = 8;
    localparam int CW = 4;

    logic clk;
    logic clr;

    usr_burst_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    usr_burst #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_q    = 0;
    int m_mode = 0;
    int m_left = 0;   // shifts still owed by an accepted burst
    int m_done = 0;

    function automatic int ref_next(int q, int mode, int lin, int rin, int par);
        int r;
        case (mode)
            1:       r = (q * 2 + rin) % 256;
            2:       r = q / 2 + lin * 128;
            3:       r = par;
            4:       r = (q * 2) % 256 + q / 128;
            5:       r = q / 2 + (q % 2) * 128;
            6:       r = q / 2 + ((q >= 128) ? 128 : 0);
            default: r = q;
        endcase
        return r;
    endfunction

    function automatic bit burstable(int mode);
        return (mode == 1) || (mode == 2) || (mode == 4) || (mode == 5) || (mode == 6);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".q"},      32'(bus.q),      32'(m_q));
        chk({tag, ".sout_l"}, 32'(bus.sout_l), 32'(m_q / 128));
        chk({tag, ".sout_r"}, 32'(bus.sout_r), 32'(m_q % 2));
        chk({tag, ".busy"},   32'(bus.busy),   32'(m_left > 0));
        chk({tag, ".done"},   32'(bus.done),   32'(m_done));
    endtask

    // Advance the model by one clock using the inputs as they stand before
    // the edge, then clock the DUT and compare.
    task automatic step(input string tag);
        int nd;
        nd = 0;
        if (m_left > 0) begin
            m_q = ref_next(m_q, m_mode, int'(bus.lin), int'(bus.rin), int'(bus.par_in));
            m_left--;
            if (m_left == 0) nd = 1;
        end else if (bus.start && burstable(int'(bus.select))) begin
            if (bus.count > 0) begin
                m_mode = int'(bus.select);
                m_left = int'(bus.count);
            end else begin
                nd = 1;
            end
        end else if (bus.en) begin
            m_q = ref_next(m_q, int'(bus.select), int'(bus.lin), int'(bus.rin), int'(bus.par_in));
        end
        m_done = nd;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic model_reset();
        m_q    = 0;
        m_left = 0;
        m_done = 0;
    endtask

    task automatic drive(input logic e, input logic [2:0] s, input logic [W-1:0] p);
        bus.en     = e;
        bus.select = s;
        bus.par_in = p;
    endtask

    initial begin
        bus.en = 0; bus.select = 0; bus.lin = 0; bus.rin = 0;
        bus.par_in = 0; bus.start = 0; bus.count = 0;
        clr = 1'b1;
        #2 clr = 1'b0;
        #1;
        model_reset();
        check_all("reset_init");
        @(posedge clk); #1;
        check_all("reset_hold");
        clr = 1'b1;

        // Async reset mid-operation with q=0xFF, observed before any edge
        drive(1, 3'd3, 8'hFF);
        step("load_ff");
        chk("q_ff", 32'(bus.q), 32'h0FF);
        drive(0, 3'd0, 8'h00);
        #2 clr = 1'b0;
        #1;
        model_reset();
        chk("async_q", 32'(bus.q), 32'h0);
        check_all("async_rst");
        @(posedge clk); #1;
        clr = 1'b1;

        // Single steps
        drive(1, 3'd3, 8'hA5); step("ld_a5"); chk("vec_load", 32'(bus.q), 32'hA5);
        drive(1, 3'd4, 8'h00); step("rol");   chk("vec_rol",  32'(bus.q), 32'h4B);
        drive(1, 3'd5, 8'h00); step("ror");   chk("vec_ror",  32'(bus.q), 32'hA5);
        drive(1, 3'd3, 8'h90); step("ld_90");
        drive(1, 3'd6, 8'h00); step("asr");   chk("vec_asr",  32'(bus.q), 32'hC8);
        drive(1, 3'd3, 8'h81); step("ld_81");
        bus.rin = 1;
        drive(1, 3'd1, 8'h00); step("shl");   chk("vec_shl",  32'(bus.q), 32'h03);
        bus.rin = 0;
        drive(1, 3'd3, 8'h81); step("ld_81b");
        bus.lin = 0;
        drive(1, 3'd2, 8'h00); step("shr");   chk("vec_shr",  32'(bus.q), 32'h40);
        drive(0, 3'd0, 8'h00); step("hold");  chk("vec_hold", 32'(bus.q), 32'h40);

        // Burst shl x3 with en=1/select=3 held after capture
        drive(1, 3'd3, 8'h01); step("ld_01");
        bus.rin = 0;
        drive(1, 3'd1, 8'hFF); bus.start = 1; bus.count = 3;
        step("b_cap");  chk("b_cap_q", 32'(bus.q), 32'h01); chk("b_cap_busy", 32'(bus.busy), 1);
        bus.start = 0;
        drive(1, 3'd3, 8'hFF);
        step("b_s1");   chk("b_s1_q", 32'(bus.q), 32'h02);
        step("b_s2");   chk("b_s2_q", 32'(bus.q), 32'h04);
        step("b_s3");   chk("b_s3_q", 32'(bus.q), 32'h08);
        chk("b_done", 32'(bus.done), 1); chk("b_busy_lo", 32'(bus.busy), 0);
        drive(0, 3'd0, 8'h00);
        step("b_after"); chk("b_done_clr", 32'(bus.done), 0);

        // Zero-count burst
        drive(0, 3'd4, 8'h00); bus.start = 1; bus.count = 0;
        step("z_cap");  chk("z_done", 32'(bus.done), 1); chk("z_busy", 32'(bus.busy), 0);
        chk("z_q", 32'(bus.q), 32'h08);
        bus.start = 0;
        step("z_after");

        // Start with load mode is a plain load
        drive(1, 3'd3, 8'h3C); bus.start = 1; bus.count = 5;
        step("ign");    chk("ign_q", 32'(bus.q), 32'h3C); chk("ign_busy", 32'(bus.busy), 0);
        bus.start = 0;
        drive(0, 3'd0, 8'h00);

        // Reset mid-burst: ror x8, abandon after 4 shifts
        drive(1, 3'd3, 8'h96); step("ld_96");
        drive(0, 3'd5, 8'h00); bus.start = 1; bus.count = 8;
        step("r_cap");
        bus.start = 0;
        for (int i = 0; i < 4; i++) step("r_shift");
        chk("r_mid_q", 32'(bus.q), 32'h69);
        #2 clr = 1'b0;
        #1;
        model_reset();
        check_all("r_async");
        step("r_held");
        chk("r_nodone", 32'(bus.done), 0);
        clr = 1'b1;
        drive(1, 3'd3, 8'h81); step("r_ld");
        drive(0, 3'd4, 8'h00); bus.start = 1; bus.count = 2;
        step("r2_cap");
        bus.start = 0;
        step("r2_s1");
        step("r2_s2");  chk("r2_q", 32'(bus.q), 32'h06); chk("r2_done", 32'(bus.done), 1);

        // Back-to-back: start accepted while done is high
        drive(1, 3'd3, 8'h01); step("bb_ld");
        drive(0, 3'd1, 8'h00); bus.rin = 0; bus.start = 1; bus.count = 1;
        step("bb_cap1");
        bus.start = 0;
        step("bb_s1");  chk("bb_done1", 32'(bus.done), 1); chk("bb_q1", 32'(bus.q), 32'h02);
        bus.select = 3'd5; bus.start = 1; bus.count = 2;
        step("bb_cap2"); chk("bb_busy2", 32'(bus.busy), 1); chk("bb_q2", 32'(bus.q), 32'h02);
        bus.start = 0;
        step("bb_s2a");
        step("bb_s2b"); chk("bb_q3", 32'(bus.q), 32'h80); chk("bb_done2", 32'(bus.done), 1);

        // Randomized traffic, including live lin/rin and ignored inputs mid-burst
        for (int i = 0; i < 400; i++) begin
            bus.en     = 1'($urandom_range(0, 1));
            bus.select = 3'($urandom_range(0, 7));
            bus.lin    = 1'($urandom_range(0, 1));
            bus.rin    = 1'($urandom_range(0, 1));
            bus.par_in = 8'($urandom_range(0, 255));
            bus.start  = ($urandom_range(0, 4) == 0);
            bus.count  = 4'($urandom_range(0, 15));
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always terminates
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/usr_burst.md
Name: usr_burst

Overview:
Parametrised universal shift register, the next generation of the team's 3-bit universal shift register. Adds a generic width, rotate and arithmetic-shift modes, serial outputs, and a burst engine that performs N shifts from a single start request with a busy/done handshake. It sits in datapath serialisers and bit-alignment logic, where software or an upstream FSM requests multi-bit shifts.

Parameters:
WIDTH, 8, register width in bits; WIDTH >= 2.
CNT_W, 4, width of the burst count port; must be at least clog2(WIDTH)+1 so that a count of WIDTH is representable.

Ports:
clk  input  1  rising-edge clock; the only clock.
clr  input  1  asynchronous, active-low reset.
en  input  1  single-step enable; acted on only when idle.
select  input  3  mode: 0 hold, 1 shl, 2 shr, 3 load, 4 rol, 5 ror, 6 asr, 7 hold (reserved).
lin  input  1  serial input entering the MSB in shr.
rin  input  1  serial input entering the LSB in shl.
par_in  input  WIDTH  parallel load data.
start  input  1  burst request; sampled only when idle.
count  input  CNT_W  number of shifts in the burst.
q  output  WIDTH  register contents.
sout_l  output  1  q[WIDTH-1], combinational from q.
sout_r  output  1  q[0], combinational from q.
busy  output  1  burst in progress.
done  output  1  one-cycle pulse at burst completion.

Behaviour:
- Reset: clr low asynchronously forces q=0, busy=0, done=0 and FSM=IDLE. Takes effect immediately, including mid-burst; the burst is abandoned with no done pulse.
- Step function next(q, mode):
  - shl = {q[W-2:0], rin}
  - shr = {lin, q[W-1:1]}
  - load = par_in
  - rol = {q[W-2:0], q[W-1]}
  - ror = {q[0], q[W-1:1]}
  - asr = {q[W-1], q[W-1:1]}
  - hold/7 = q
- FSM states: IDLE, RUN.
- IDLE, priority at each edge:
  - start=1 and select in {1,2,4,5,6}, count>0: latch mode=select and remaining=count; go to RUN; busy=1. q does not change on this edge.
  - start=1 and select in {1,2,4,5,6}, count=0: no shift; done=1 for the next cycle; stay IDLE.
  - start=1 with select in {0,3,7}: start is ignored and the cycle is treated as a single step under the en rule.
  - en=1: q<=next(q, select). Latency 1 edge.
  - Otherwise: q holds.
- RUN, at each edge:
  - q<=next(q, latched mode); remaining decrements.
  - When the shift that brings remaining to 0 happens: go to IDLE, busy=0, done=1 for exactly one cycle.
  - The burst therefore performs exactly count shifts on edges 1..count after the capture edge.
  - busy is high for count cycles.
- During RUN:
  - en, select, start, count and par_in are ignored.
  - lin and rin are sampled live on each shift edge.
- done is a registered pulse that clears on the following edge.
- A start in the same cycle that done is high is accepted normally, since the FSM is IDLE.
- count greater than WIDTH is legal; shl/shr/asr saturate naturally, and rol/ror wrap modulo WIDTH.
- Outputs are registered except sout_l and sout_r.

Decomposition:
- Package usr_pkg holds:
  - mode constants MODE_HOLD..MODE_RSVD (3-bit);
  - FSM state constants ST_IDLE and ST_RUN;
  - a function is_shift_mode(mode).
- Sub-module usr_step: purely combinational, parameter WIDTH; inputs q, mode, lin, rin, par_in; output nxt.
- The top-level usr_burst instantiates usr_step once and holds the FSM, counter and q register.

Test Plan:
- Reset: drive clr=0 mid-operation with q=0xFF -> q=0x00, busy=0, done=0 immediately, before the next clk edge.
- Steps (WIDTH=8, en=1):
  - load par_in=0xA5 -> q=0xA5;
  - rol -> 0x4B;
  - ror -> 0xA5;
  - asr on 0x90 -> 0xC8;
  - shl with rin=1 on 0x81 -> 0x03;
  - shr with lin=0 on 0x81 -> 0x40.
- Burst: q=0x01, select=1, rin=0, start=1, count=3 -> busy high 3 cycles, q goes 0x02, 0x04, 0x08, then done=1 for 1 cycle; with en=1 and select=3 held throughout, q is not loaded.
- Zero-count and ignored start:
  - count=0, select=4 -> no shift, done=1 the next cycle, busy stays 0.
  - start with select=3 and en=1 -> plain load, no busy.
- Reset mid-burst: count=8 ror, clr=0 after 4 shifts -> q=0, busy=0, no done pulse; after clr=1, a new burst runs correctly.
- Back-to-back bursts: start asserted in the cycle done=1 -> second burst captured; busy rises on the next edge.
